// File: rtl/kyber_pkg.sv
// Shared constants, hash-core encodings and the PRF/CBD sampler state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int KYBER_N   = 256;
  localparam int PRF_BYTES = 128;
  localparam int HASH_OUT_W = 1344;

  // o_hash_en encodings towards the shared hash core
  localparam logic [1:0] HASH_EN_IDLE  = 2'b00;
  localparam logic [1:0] HASH_EN_START = 2'b01;
  localparam logic [1:0] HASH_EN_ACK   = 2'b10;

  localparam logic [1:0] HASH_MODE_SHAKE256 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } cbd_state_e;

endpackage

// File: rtl/cbd2_nibble.sv
// CBD eta=2 on one nibble: (b0+b1)-(b2+b3), widened to COEF_W bits.
// Latency: combinational.
// Backpressure: none; CBD_SIGNED_OUT_EN selects sign-extended output instead of mod-Q.
module cbd2_nibble #(
  parameter int COEF_W = 12
`ifndef CBD_SIGNED_OUT_EN
  , parameter int Q = 3329
`endif
) (
  input  logic [3:0]        i_nib,
  output logic [COEF_W-1:0] o_coef
);

  // s lives in [-2,2], so a 3-bit two's complement value is enough
  logic [2:0] s;

  // signed sample, then map to the output representation
  always_comb begin
    s = ({2'b00, i_nib[0]} + {2'b00, i_nib[1]}) - ({2'b00, i_nib[2]} + {2'b00, i_nib[3]});
`ifdef CBD_SIGNED_OUT_EN
    o_coef = {{(COEF_W-3){s[2]}}, s};
`else
    // Q + s for negative s: adding the sign-extended value wraps back into [Q-2, Q-1]
    o_coef = s[2] ? (COEF_W'(Q) + {{(COEF_W-3){1'b1}}, s}) : {{(COEF_W-3){1'b0}}, s};
`endif
  end

endmodule

// File: rtl/prf_cbd_sampler.sv
// PRF request (SHAKE256 over sigma||nonce) then CBD2 sampling of 256 coefficients, LANES per beat.
// Latency: start to first o_valid = 2 cycles + hash latency; then 256/LANES beats at full rate.
// Backpressure: o_valid/i_ready; o_coef/o_index held while stalled. CBD_SIGNED_OUT_EN selects signed lanes.
module prf_cbd_sampler
  import kyber_pkg::*;
#(
  parameter int Q      = KYBER_Q,
  parameter int COEF_W = 12,
  parameter int LANES  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic [255:0]              i_sigma,
  input  logic [7:0]                i_nonce,
  output logic [1:0]                o_hash_en,
  output logic [271:0]              o_hash_in,
  output logic [1:0]                o_hash_mode,
  input  logic                      i_hash_done,
  input  logic [HASH_OUT_W-1:0]     i_hash_out,
  output logic [LANES*COEF_W-1:0]   o_coef,
  output logic [7:0]                o_index,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int         BUF_W    = PRF_BYTES * 8;
  localparam int         SHIFT_W  = LANES * 4;
  localparam logic [7:0] LAST_IDX = 8'(KYBER_N - LANES);

  cbd_state_e         state_q, state_d;
  logic [255:0]       sigma_q, sigma_d;
  logic [7:0]         nonce_q, nonce_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [7:0]         index_q, index_d;

  // only the first 128 PRF bytes are sampled; the tail is intentionally dropped
  logic unused_hash_tail;
  assign unused_hash_tail = ^i_hash_out[HASH_OUT_W-BUF_W-1:0];

  // FSM next-state, latches, PRF buffer shifting and index counting
  always_comb begin
    state_d   = state_q;
    sigma_d   = sigma_q;
    nonce_d   = nonce_q;
    buf_d     = buf_q;
    index_d   = index_q;
    o_hash_en = HASH_EN_IDLE;
    o_valid   = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sigma_d = i_sigma;
          nonce_d = i_nonce;
          index_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        o_hash_en = HASH_EN_START;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_hash_done) begin
          o_hash_en = HASH_EN_ACK;
          buf_d     = i_hash_out[HASH_OUT_W-1 -: BUF_W];
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        o_valid = 1'b1;
        if (i_ready) begin
          // byte 0 sits at the MSB end, so consumed bytes leave to the left
          buf_d   = buf_q << SHIFT_W;
          index_d = index_q + 8'(LANES);
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      sigma_q <= '0;
      nonce_q <= '0;
      buf_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      sigma_q <= sigma_d;
      nonce_q <= nonce_d;
      buf_q   <= buf_d;
      index_q <= index_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_index     = index_q;
  assign o_hash_in   = {8'd0, sigma_q, nonce_q};
  assign o_hash_mode = HASH_MODE_SHAKE256;

  // lane l reads byte l/2 of the buffer head: even lanes low nibble, odd lanes high nibble
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int NIB_MSB = BUF_W - 1 - 8 * (l / 2) - ((l % 2 == 1) ? 0 : 4);
    cbd2_nibble #(
      .COEF_W(COEF_W)
`ifndef CBD_SIGNED_OUT_EN
      , .Q(Q)
`endif
    ) u_cbd (
      .i_nib (buf_q[NIB_MSB -: 4]),
      .o_coef(o_coef[COEF_W*l +: COEF_W])
    );
  end

endmodule

// File: tb/tb_prf_cbd_sampler.sv
// Scoreboard bench: three samplers (LANES = 2, 4, 8) share one hash model and start/sigma/nonce.
// Expected beats are pushed when the hash model answers; a monitor pops them on every handshake.
// Reference: plain-arithmetic CBD2 over the hash bytes, built independently of the RTL structure.
module tb_prf_cbd_sampler;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [255:0]   sigma;
  logic [7:0]     nonce;
  logic           hash_done;
  logic [1343:0]  hash_out;

  logic [1:0]     hash_en_w  [3];
  logic [271:0]   hash_in_w  [3];
  logic [1:0]     mode_w     [3];
  logic [7:0]     index_w    [3];
  logic           valid_w    [3];
  logic           busy_w     [3];
  logic           done_w     [3];
  logic           rdy_w      [3];
  logic [95:0]    coef_w     [3];

  int checks = 0;
  int errors = 0;

  // bench-side expectations and control
  logic [255:0]   exp_sigma;
  logic [7:0]     exp_nonce;
  logic [1343:0]  hash_pat;
  bit             rand_rdy;
  bit             stall_en;
  logic [103:0]   exp_q [3][$];

  // monitor-owned counters
  int done_cnt [3];
  int beats    [3];
  int vcyc     [3];
  int hreq_cnt;
  bit             held_v [3];
  logic [103:0]   held   [3];

  // snapshots taken by the main sequence at job start
  int s_done [3];
  int s_beats[3];
  int s_vcyc [3];
  int s_hreq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L = 2 << g;
    logic [L*12-1:0] c;
    logic            rdy;
    int              stall_n;

    prf_cbd_sampler #(.LANES(L)) u_dut (
      .i_clk      (clk),
      .i_rstn     (rst_n),
      .i_start    (start),
      .i_sigma    (sigma),
      .i_nonce    (nonce),
      .o_hash_en  (hash_en_w[g]),
      .o_hash_in  (hash_in_w[g]),
      .o_hash_mode(mode_w[g]),
      .i_hash_done(hash_done),
      .i_hash_out (hash_out),
      .o_coef     (c),
      .o_index    (index_w[g]),
      .o_valid    (valid_w[g]),
      .i_ready    (rdy),
      .o_busy     (busy_w[g]),
      .o_done     (done_w[g])
    );
    assign coef_w[g] = 96'(c);
    assign rdy_w[g]  = rdy;

    // ready driver; instance 1 can hold a 5-cycle stall on the beat with index 40
    initial begin
      rdy = 1'b1;
      stall_n = 0;
      forever begin
        @(posedge clk);
        #1;
        if (!stall_en) stall_n = 0;
        if (g == 1 && stall_en && valid_w[1] && index_w[1] == 8'd40 && stall_n < 5) begin
          rdy = 1'b0;
          stall_n++;
        end else if (rand_rdy) begin
          rdy = ($urandom_range(0, 3) != 0);
        end else begin
          rdy = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_coef(input logic [1343:0] h, input int idx);
    logic [7:0] b;
    logic [3:0] nib;
    int s;
    b   = h[1343 - 8*(idx/2) -: 8];
    nib = (idx % 2 == 1) ? b[7:4] : b[3:0];
    s   = int'(nib[0]) + int'(nib[1]) - int'(nib[2]) - int'(nib[3]);
`ifdef CBD_SIGNED_OUT_EN
    return 12'(s);
`else
    return (s < 0) ? 12'(3329 + s) : 12'(s);
`endif
  endfunction

  task automatic push_expected(input logic [1343:0] h);
    for (int i = 0; i < 3; i++) begin
      int lanes;
      lanes = 2 << i;
      for (int k = 0; k < 256 / lanes; k++) begin
        logic [103:0] e;
        e = '0;
        e[103:96] = 8'(k * lanes);
        for (int l = 0; l < lanes; l++) e[12*l +: 12] = ref_coef(h, k * lanes + l);
        exp_q[i].push_back(e);
      end
    end
  endtask

  // hash core model: answers each request after 0..3 idle WAIT cycles, pokes spurious done while idle
  initial begin
    hash_done = 1'b0;
    hash_out  = '0;
    hreq_cnt  = 0;
    forever begin
      @(negedge clk);
      hash_done = 1'b0;
      if (!rst_n) continue;
      if (hash_en_w[0] == 2'b01) begin
        hreq_cnt++;
        for (int i = 0; i < 3; i++) begin
          check("hash_in", hash_in_w[i], {8'd0, exp_sigma, exp_nonce});
          check("hash_mode", 272'(mode_w[i]), 272'(3));
        end
        @(negedge clk);
        check("hash_en_one_cycle", 272'(hash_en_w[0]), 272'(0));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (!rst_n) continue;
        hash_out  = hash_pat;
        hash_done = 1'b1;
        push_expected(hash_pat);
        #1;
        for (int i = 0; i < 3; i++) check("hash_ack", 272'(hash_en_w[i]), 272'(2'b10));
      end else if (!busy_w[0] && $urandom_range(0, 3) == 0) begin
        hash_out  = {42{$urandom}};
        hash_done = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check("spurious_done_ignored", 272'(hash_en_w[i]), 272'(0));
      end
    end
  end

  // monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0; beats[i] = 0; vcyc[i] = 0; held_v[i] = 1'b0; held[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          held_v[i] = 1'b0;
          continue;
        end
        if (held_v[i]) check("stall_hold", {valid_w[i], index_w[i], coef_w[i]}, {1'b1, held[i]});
        held_v[i] = 1'b0;
        if (valid_w[i]) begin
          vcyc[i]++;
          if (rdy_w[i]) begin
            beats[i]++;
            if (exp_q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: lanes %0d index %0d with empty scoreboard", 2 << i, index_w[i]);
            end else begin
              check("beat", {index_w[i], coef_w[i]}, exp_q[i].pop_front());
            end
          end else begin
            held_v[i] = 1'b1;
            held[i]   = {index_w[i], coef_w[i]};
          end
        end
        if (done_w[i]) done_cnt[i]++;
      end
    end
  end

  task automatic start_job(input logic [255:0] s, input logic [7:0] n, input logic [1343:0] h);
    exp_sigma = s;
    exp_nonce = n;
    hash_pat  = h;
    for (int i = 0; i < 3; i++) begin
      s_done[i] = done_cnt[i]; s_beats[i] = beats[i]; s_vcyc[i] = vcyc[i];
    end
    s_hreq = hreq_cnt;
    @(posedge clk); #1;
    sigma = s; nonce = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input bit full_rate);
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 6000 && !all_done; t++) begin
      @(negedge clk); #2;
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) if (done_cnt[i] <= s_done[i]) all_done = 1'b0;
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: not all instances reached o_done, required within 6000 cycles");
    end
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check("done_once", 272'(done_cnt[i] - s_done[i]), 272'(1));
      check("beat_count", 272'(beats[i] - s_beats[i]), 272'(256 / (2 << i)));
      check("scoreboard_empty", 272'(exp_q[i].size()), 272'(0));
      check("latched_key", hash_in_w[i], {8'd0, exp_sigma, exp_nonce});
      check("idle_after_done", 272'(busy_w[i]), 272'(0));
      if (full_rate) check("no_bubbles", 272'(vcyc[i] - s_vcyc[i]), 272'(256 / (2 << i)));
    end
    check("one_hash_request", 272'(hreq_cnt - s_hreq), 272'(1));
  endtask

  task automatic wait_inst1(input int idx, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000 && !ok; t++) begin
      @(negedge clk); #2;
      if (valid_w[1] && (idx < 0 || index_w[1] == 8'(idx))) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_beat_timeout: lanes 4 beat index %0d never presented", idx);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 3; i++) begin
      check(name, {hash_en_w[i], valid_w[i], done_w[i], busy_w[i], index_w[i], coef_w[i]}, '0);
    end
  endtask

  function automatic logic [1343:0] rand_hash();
    logic [1343:0] h;
    for (int w = 0; w < 42; w++) h[32*w +: 32] = $urandom;
    return h;
  endfunction

  initial begin
    logic [1343:0] h;
    logic [47:0]   beat0_exp;
    bit            ok;
    int            d_snap [3];

    rst_n = 1'b0; start = 1'b0; sigma = '0; nonce = '0;
    rand_rdy = 1'b0; stall_en = 1'b0;
    exp_sigma = '0; exp_nonce = '0; hash_pat = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // zero key and zero hash: every coefficient is 0, full-rate stream
    start_job(256'd0, 8'h05, '0);
    finish_job(1'b1);

    // known leading bytes C3, 0F
    h = rand_hash();
    h[1343 -: 16] = 16'hC30F;
`ifdef CBD_SIGNED_OUT_EN
    beat0_exp = {12'd0, 12'd0, 12'hFFE, 12'd2};
`else
    beat0_exp = {12'd0, 12'd0, 12'd3327, 12'd2};
`endif
    start_job({8{$urandom}}, 8'($urandom), h);
    wait_inst1(0, ok);
    if (ok) check("beat0_known_bytes", 272'(coef_w[1][47:0]), 272'(beat0_exp));
    finish_job(1'b1);

    // 5-cycle stall on beat 10 of the 4-lane instance
    stall_en = 1'b1;
    start_job({8{$urandom}}, 8'($urandom), rand_hash());
    finish_job(1'b0);
    check("stall_cycles", 272'(gen_dut[1].stall_n), 272'(5));
    stall_en = 1'b0;

    // start pulse with a different key while streaming is ignored
    rand_rdy = 1'b1;
    start_job({8{$urandom}}, 8'($urandom), rand_hash());
    wait_inst1(-1, ok);
    @(posedge clk); #1;
    sigma = ~exp_sigma; nonce = ~exp_nonce; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_job(1'b0);
    rand_rdy = 1'b0;

    // reset at beat 20 of the 4-lane instance: outputs clear, no o_done
    start_job({8{$urandom}}, 8'($urandom), rand_hash());
    wait_inst1(80, ok);
    for (int i = 0; i < 3; i++) d_snap[i] = done_cnt[i];
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) check("no_done_after_reset", 272'(done_cnt[i] - d_snap[i]), 272'(0));
    check_reset_outputs("idle_after_reset");

    // randomized keys, hashes and ready patterns
    for (int r = 0; r < 3; r++) begin
      rand_rdy = (r != 0);
      start_job({8{$urandom}}, 8'($urandom), rand_hash());
      finish_job(r == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
